// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit among N_REQ requesters.
// Define LOGIC_OP_ARB_STATS_EN to add per-requester saturating grant counters on stat_grants.
module logic_op_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2:0]             rsp_op,
    output logic [WIDTH-1:0]       rsp_data
`ifdef LOGIC_OP_ARB_STATS_EN
    ,
    output logic [16*N_REQ-1:0]    stat_grants
`endif
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [2:0]        rsp_op_q;
    logic [WIDTH-1:0]  rsp_data_q;

    logic              can_accept;
    logic              grant_any;
    logic              accept;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   idx;
    logic [2:0]        op_d;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH-1:0]  data_d;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(last_q) + k) % N_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    assign can_accept = !rst && ((state_q == EMPTY) || rsp_ready);
    assign accept     = can_accept && grant_any;
    assign req_ready  = accept ? (N_REQ'(1) << grant_id) : '0;

    assign op_d  = req_op[32'(grant_id)*3 +: 3];
    assign a_sel = req_a[32'(grant_id)*WIDTH +: WIDTH];
    assign b_sel = req_b[32'(grant_id)*WIDTH +: WIDTH];

    always_comb begin
        data_d = a_sel;
        case (op_d)
            3'd0:    data_d = a_sel & b_sel;
            3'd1:    data_d = a_sel | b_sel;
            3'd2:    data_d = ~(a_sel & b_sel);
            3'd3:    data_d = ~(a_sel | b_sel);
            3'd4:    data_d = a_sel ^ b_sel;
            3'd5:    data_d = ~(a_sel ^ b_sel);
            3'd6:    data_d = ~a_sel;
            default: data_d = a_sel;
        endcase
    end

`ifdef LOGIC_OP_ARB_STATS_EN
    logic [15:0] grants_q [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_grants[g*16 +: 16] = grants_q[g];
    end
`endif

    // Result slot: a drain and a refill may happen on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            last_q     <= ID_W'(N_REQ - 1);
            rsp_id_q   <= '0;
            rsp_op_q   <= '0;
            rsp_data_q <= '0;
`ifdef LOGIC_OP_ARB_STATS_EN
            for (int unsigned i = 0; i < N_REQ; i++) grants_q[i] <= '0;
`endif
        end else begin
            if (accept) begin
                state_q    <= FULL;
                last_q     <= grant_id;
                rsp_id_q   <= grant_id;
                rsp_op_q   <= op_d;
                rsp_data_q <= data_d;
`ifdef LOGIC_OP_ARB_STATS_EN
                if (grants_q[grant_id] != 16'hFFFF)
                    grants_q[grant_id] <= grants_q[grant_id] + 16'd1;
`endif
            end else if ((state_q == FULL) && rsp_ready) begin
                state_q <= EMPTY;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: vector table, directed corner sequences and a result scoreboard.
module tb_logic_op_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    typedef struct packed {
        logic [1:0] id;
        logic [2:0] op;
        logic [7:0] data;
    } rsp_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [2:0]     rsp_op;
    logic [7:0]     rsp_data;
`ifdef LOGIC_OP_ARB_STATS_EN
    logic [16*N-1:0] stat_grants;
`endif

    logic_op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_op    (rsp_op),
        .rsp_data  (rsp_data)
`ifdef LOGIC_OP_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk;
    int         n_fail;
    logic       m_full;
    int         m_last;
    rsp_t       exp_q[$];
    logic [7:0] exp_data [N];
    logic [N-1:0] seen_rdy;
    vec_t       tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_req(input int i, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] e);
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        exp_data[i]      = e;
    endtask

    // Sample at the falling edge, check grant and result, then advance the model past the rising edge.
    task automatic cycle();
        logic [N-1:0] er;
        int           g;
        rsp_t         e;
        rsp_t         got;
        @(negedge clk);
        g = -1;
        if (!rst && (!m_full || rsp_ready)) g = model_grant(req_valid, m_last);
        er = (g >= 0) ? (4'(1) << g) : 4'(0);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        seen_rdy = req_ready;
        if (!rst && m_full && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: got response id %0d with no expected entry", rsp_id);
            end else begin
                e = exp_q.pop_front();
                got = '{id: rsp_id, op: rsp_op, data: rsp_data};
                chk("rsp_id", 32'(got.id), 32'(e.id));
                chk("rsp_op", 32'(got.op), 32'(e.op));
                chk("rsp_data", 32'(got.data), 32'(e.data));
            end
        end
        if (rst) begin
            m_full = 1'b0;
            m_last = N - 1;
            exp_q.delete();
        end else if (g >= 0) begin
            e.id   = 2'(g);
            e.op   = req_op[3*g +: 3];
            e.data = exp_data[g];
            exp_q.push_back(e);
            m_full = 1'b1;
            m_last = g;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] r_id;
        logic [2:0] r_op;
        logic [7:0] r_data;
        logic [N-1:0] prev;
        logic [N-1:0] acc;

        tbl[0] = '{3'd0, 8'hA5, 8'h0F, 8'h05};
        tbl[1] = '{3'd1, 8'hA5, 8'h0F, 8'hAF};
        tbl[2] = '{3'd2, 8'hA5, 8'h0F, 8'hFA};
        tbl[3] = '{3'd3, 8'hA5, 8'h0F, 8'h50};
        tbl[4] = '{3'd4, 8'hA5, 8'h0F, 8'hAA};
        tbl[5] = '{3'd5, 8'hA5, 8'h0F, 8'h55};
        tbl[6] = '{3'd6, 8'hA5, 8'h0F, 8'h5A};
        tbl[7] = '{3'd7, 8'hA5, 8'h0F, 8'hA5};

        n_chk = 0;
        n_fail = 0;
        m_full = 1'b0;
        m_last = N - 1;
        seen_rdy = '0;
        rst = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) exp_data[i] = '0;

        // Reset then single request
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_op", 32'(rsp_op), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        drive_req(0, 3'd0, 8'hF0, 8'h3C, 8'h30);
        req_valid = 4'b0001;
        cycle();
        chk("first_grant", 32'(seen_rdy), 32'h1);
        req_valid = '0;
        cycle();
        cycle();

        // Opcode sweep on requester 2, back-to-back
        for (int v = 0; v < 8; v++) begin
            drive_req(2, tbl[v].op, tbl[v].a, tbl[v].b, tbl[v].exp);
            req_valid = 4'b0100;
            cycle();
        end
        req_valid = '0;
        cycle();
        cycle();

        // Round-robin fairness from reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            drive_req(i, 3'(i + 1), 8'(8'h11 * (i + 1)), 8'(8'h0F << i), 8'h00);
            exp_data[i] = ref_op(3'(i + 1), 8'(8'h11 * (i + 1)), 8'(8'h0F << i));
        end
        req_valid = 4'b1111;
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_order", 32'(seen_rdy), 32'(4'(1) << (k % 4)));
            chk("rr_no_repeat", 32'(seen_rdy & prev), 32'd0);
            prev = seen_rdy;
        end
        req_valid = '0;
        cycle();
        cycle();

        // Backpressure while FULL, then drain and refill in one cycle
        drive_req(1, 3'd4, 8'h3C, 8'hFF, 8'hC3);
        req_valid = 4'b0010;
        cycle();
        rsp_ready = 1'b0;
        req_valid = 4'b0101;
        r_id = rsp_id;
        r_op = rsp_op;
        r_data = rsp_data;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_no_ready", 32'(seen_rdy), 32'd0);
            chk("bp_id_stable", 32'(rsp_id), 32'(r_id));
            chk("bp_op_stable", 32'(rsp_op), 32'(r_op));
            chk("bp_data_stable", 32'(rsp_data), 32'(r_data));
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_refill_grant", 32'(seen_rdy), 32'h4);
        chk("bp_refill_valid", 32'(rsp_valid), 32'd1);
        req_valid = '0;
        cycle();
        cycle();

        // Reset mid-stream drops the pending result
        do_reset();
        drive_req(3, 3'd7, 8'h77, 8'h00, 8'h77);
        req_valid = 4'b1000;
        cycle();
        req_valid = '0;
        rsp_ready = 1'b0;
        chk("mid_full_id", 32'(rsp_id), 32'd3);
        rst = 1'b1;
        req_valid = 4'b1001;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        cycle();
        chk("mid_rst_first_grant", 32'(seen_rdy), 32'h1);
        req_valid = '0;
        cycle();
        cycle();

        // Random traffic with random consumer backpressure
        acc = '0;
        for (int t = 0; t < 300; t++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    logic [2:0] op;
                    logic [7:0] a;
                    logic [7:0] b;
                    op = 3'($urandom_range(0, 7));
                    a = 8'($urandom);
                    b = 8'($urandom);
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    drive_req(i, op, a, b, ref_op(op, a, b));
                end
            end
            cycle();
            acc = seen_rdy & req_valid;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef LOGIC_OP_ARB_STATS_EN
        // Saturating grant counters
        do_reset();
        drive_req(1, 3'd7, 8'h01, 8'h00, 8'h01);
        req_valid = 4'b0010;
        for (int k = 0; k < 70000; k++) cycle();
        req_valid = '0;
        cycle();
        cycle();
        chk("stat_req1_sat", 32'(stat_grants[31:16]), 32'hFFFF);
        chk("stat_req0", 32'(stat_grants[15:0]), 32'd0);
        chk("stat_req2", 32'(stat_grants[47:32]), 32'd0);
        chk("stat_req3", 32'(stat_grants[63:48]), 32'd0);
        do_reset();
        chk("stat_rst_lo", 32'(stat_grants[31:0]), 32'd0);
        chk("stat_rst_hi", 32'(stat_grants[63:32]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
